// File: rtl/clock_time_ctrl_if.sv
// rtl/clock_time_ctrl_if.sv - button inputs and HH:MM display outputs of clock_time_ctrl
// The pm flag exists only when TWELVE_HOUR_EN is defined.
interface clock_time_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] h10;
  logic [3:0] h1;
  logic [3:0] m10;
  logic [3:0] m1;
  logic [3:0] blank;
  logic       sec_pulse;
  logic [1:0] mode;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif

  modport master (
`ifdef TWELVE_HOUR_EN
    input  pm,
`endif
    output btn_mode, btn_inc,
    input  h10, h1, m10, m1, blank, sec_pulse, mode
  );

  modport slave (
`ifdef TWELVE_HOUR_EN
    output pm,
`endif
    input  btn_mode, btn_inc,
    output h10, h1, m10, m1, blank, sec_pulse, mode
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - 1 s prescaler, BCD HH:MM timekeeping and button-driven time-set FSM
// Define TWELVE_HOUR_EN for 12 h display (12,01..11) with an AM/PM flag on io.pm.
module clock_time_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 10000000,
  parameter int unsigned BLINK_TICKS   = 2500000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst,
  clock_time_ctrl_if.slave io
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} mode_e;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic [5:0]       sec_q, sec_d;
  logic [3:0]       h10_q, h10_d, h1_q, h1_d, m10_q, m10_d, m1_q, m1_d;
  logic [3:0]       blank_q, blank_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic [1:0]       btn_s_q, btn_s_d, btn_p_q, btn_p_d, btn_arm_q, btn_arm_d;
  logic [1:0]       press;
  logic             mode_press, inc_press, tick;
  logic [3:0]       hinc_h10, hinc_h1, minc_m10, minc_m1;
  logic             min_carry;
`ifdef TWELVE_HOUR_EN
  logic             pm_q, pm_d, hinc_pm;
`endif

  // A press needs the button to have been seen low since reset, so a level held through reset is ignored.
  always_comb begin
    btn_s_d   = {io.btn_mode, io.btn_inc};
    btn_p_d   = btn_s_q;
    btn_arm_d = btn_arm_q | ~btn_s_d;
  end

  assign press      = btn_s_q & ~btn_p_q & btn_arm_q;
  assign mode_press = press[1];
  assign inc_press  = press[0];
  assign tick       = (mode_q == RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    hinc_h10 = h10_q;
    hinc_h1  = h1_q + 4'd1;
`ifdef TWELVE_HOUR_EN
    hinc_pm  = pm_q;
    if (h10_q == 4'd1 && h1_q == 4'd2) begin
      hinc_h10 = 4'd0;
      hinc_h1  = 4'd1;
    end else if (h10_q == 4'd1 && h1_q == 4'd1) begin
      hinc_h1  = 4'd2;
      hinc_pm  = ~pm_q;
    end else if (h1_q == 4'd9) begin
      hinc_h10 = 4'd1;
      hinc_h1  = 4'd0;
    end
`else
    if (h10_q == 4'd2 && h1_q == 4'd3) begin
      hinc_h10 = 4'd0;
      hinc_h1  = 4'd0;
    end else if (h1_q == 4'd9) begin
      hinc_h10 = h10_q + 4'd1;
      hinc_h1  = 4'd0;
    end
`endif
    minc_m10  = m10_q;
    minc_m1   = m1_q + 4'd1;
    min_carry = 1'b0;
    if (m1_q == 4'd9) begin
      minc_m1 = 4'd0;
      if (m10_q == 4'd5) begin
        minc_m10  = 4'd0;
        min_carry = 1'b1;
      end else begin
        minc_m10 = m10_q + 4'd1;
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    sec_d       = sec_q;
    h10_d       = h10_q;
    h1_d        = h1_q;
    m10_d       = m10_q;
    m1_d        = m1_q;
    sec_pulse_d = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_d        = pm_q;
`endif
    // Mode press outranks both a same-cycle tick and a same-cycle inc press.
    if (mode_press) begin
      presc_d     = '0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
      case (mode_q)
        RUN: begin
          mode_d = SET_HOUR;
          sec_d  = 6'd0;
        end
        SET_HOUR: mode_d = SET_MIN;
        default: begin
          mode_d = RUN;
          sec_d  = 6'd0;
        end
      endcase
    end else if (mode_q == RUN) begin
      if (tick) begin
        presc_d     = '0;
        sec_pulse_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          m10_d = minc_m10;
          m1_d  = minc_m1;
          if (min_carry) begin
            h10_d = hinc_h10;
            h1_d  = hinc_h1;
`ifdef TWELVE_HOUR_EN
            pm_d  = hinc_pm;
`endif
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + CNT_ONE;
      end
    end else if (inc_press) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
      if (mode_q == SET_HOUR) begin
        h10_d = hinc_h10;
        h1_d  = hinc_h1;
`ifdef TWELVE_HOUR_EN
        pm_d  = hinc_pm;
`endif
      end else begin
        m10_d = minc_m10;
        m1_d  = minc_m1;
      end
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_ONE;
    end

    case (mode_d)
      SET_HOUR: blank_d = {blink_ph_d, blink_ph_d, 2'b00};
      SET_MIN:  blank_d = {2'b00, blink_ph_d, blink_ph_d};
      default:  blank_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      sec_q       <= 6'd0;
`ifdef TWELVE_HOUR_EN
      h10_q       <= 4'd1;
      h1_q        <= 4'd2;
      pm_q        <= 1'b0;
`else
      h10_q       <= 4'd0;
      h1_q        <= 4'd0;
`endif
      m10_q       <= 4'd0;
      m1_q        <= 4'd0;
      blank_q     <= 4'b0000;
      sec_pulse_q <= 1'b0;
      btn_s_q     <= 2'b00;
      btn_p_q     <= 2'b00;
      btn_arm_q   <= 2'b00;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      sec_q       <= sec_d;
      h10_q       <= h10_d;
      h1_q        <= h1_d;
`ifdef TWELVE_HOUR_EN
      pm_q        <= pm_d;
`endif
      m10_q       <= m10_d;
      m1_q        <= m1_d;
      blank_q     <= blank_d;
      sec_pulse_q <= sec_pulse_d;
      btn_s_q     <= btn_s_d;
      btn_p_q     <= btn_p_d;
      btn_arm_q   <= btn_arm_d;
    end
  end

  assign io.h10       = h10_q;
  assign io.h1        = h1_q;
  assign io.m10       = m10_q;
  assign io.m1        = m1_q;
  assign io.blank     = blank_q;
  assign io.sec_pulse = sec_pulse_q;
  assign io.mode      = mode_q;
`ifdef TWELVE_HOUR_EN
  assign io.pm        = pm_q;
`endif
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - clock_time_ctrl against a seconds-of-day reference model, directed plus random buttons
module tb_clock_time_ctrl;
  localparam int T = 4;
  localparam int B = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(.TICKS_PER_SEC(T), .BLINK_TICKS(B), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: time kept as seconds of day, displayed format derived on compare.
  int m_tod = 0, m_mode = 0, m_presc = 0, m_bcnt = 0;
  bit m_phase = 0, m_sp = 0;
  bit lm1 = 1, lm2 = 1, li1 = 1, li2 = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hour_digits(input int hr);
    int hd;
`ifdef TWELVE_HOUR_EN
    hd = (hr % 12 == 0) ? 12 : hr % 12;
`else
    hd = hr;
`endif
    return {4'(hd / 10), 4'(hd % 10)};
  endfunction

  function automatic logic [7:0] min_digits(input int mn);
    return {4'(mn / 10), 4'(mn % 10)};
  endfunction

  task automatic model_edge();
    bit pm_, pi_, tk;
    int hr, mn;
    if (rst) begin
      m_tod = 0; m_mode = 0; m_presc = 0; m_bcnt = 0; m_phase = 0; m_sp = 0;
      lm1 = 1; lm2 = 1; li1 = 1; li2 = 1;
      return;
    end
    pm_  = lm1 & ~lm2;
    pi_  = li1 & ~li2;
    tk   = (m_mode == 0) && (m_presc == T - 1);
    m_sp = 0;
    if (pm_) begin
      if (m_mode != 1) m_tod -= m_tod % 60;
      m_mode  = (m_mode + 1) % 3;
      m_presc = 0; m_bcnt = 0; m_phase = 0;
    end else if (m_mode == 0) begin
      if (tk) begin
        m_tod   = (m_tod + 1) % 86400;
        m_presc = 0;
        m_sp    = 1;
      end else begin
        m_presc++;
      end
    end else if (pi_) begin
      hr = m_tod / 3600;
      mn = (m_tod / 60) % 60;
      if (m_mode == 1) hr = (hr + 1) % 24;
      else             mn = (mn + 1) % 60;
      m_tod  = hr * 3600 + mn * 60;
      m_bcnt = 0; m_phase = 0;
    end else if (m_bcnt == B - 1) begin
      m_bcnt  = 0;
      m_phase = ~m_phase;
    end else begin
      m_bcnt++;
    end
    lm2 = lm1; lm1 = bus.btn_mode;
    li2 = li1; li1 = bus.btn_inc;
  endtask

  task automatic compare_all();
    int hr;
    logic [3:0] eb;
    hr = m_tod / 3600;
    eb = (m_mode == 1) ? {m_phase, m_phase, 2'b00} :
         (m_mode == 2) ? {2'b00, m_phase, m_phase} : 4'b0000;
    check("hours", {bus.h10, bus.h1}, hour_digits(hr));
    check("minutes", {bus.m10, bus.m1}, min_digits((m_tod / 60) % 60));
    check("blank", bus.blank, eb);
    check("sec_pulse", bus.sec_pulse, m_sp);
    check("mode", bus.mode, m_mode);
`ifdef TWELVE_HOUR_EN
    check("pm", bus.pm, hr >= 12);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic press(input bit is_mode);
    if (is_mode) bus.btn_mode = 1'b1; else bus.btn_inc = 1'b1;
    step(); step();
    if (is_mode) bus.btn_mode = 1'b0; else bus.btn_inc = 1'b0;
    step(); step();
  endtask

  initial begin
    int n, saved_h, r;
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (3) step();
    check("rst_hours", {bus.h10, bus.h1}, hour_digits(0));
    check("rst_blank", bus.blank, 4'b0000);
    rst = 1'b0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (i == 4) check("first_tick", bus.sec_pulse, 1'b1);
    end
    check("m1_after_240", bus.m1, 4'd1);

    // Preload 23:59 through the set modes, then 59 + 1 ticks.
    press(1'b1);
    n = (23 - m_tod / 3600 + 24) % 24;
    repeat (n) press(1'b0);
    press(1'b1);
    n = (59 - (m_tod / 60) % 60 + 60) % 60;
    repeat (n) press(1'b0);
    press(1'b1);
    repeat (234) step();
    check("pre_wrap_hours", {bus.h10, bus.h1}, hour_digits(23));
    check("pre_wrap_min", {bus.m10, bus.m1}, 8'h59);
`ifdef TWELVE_HOUR_EN
    check("pre_wrap_pm", bus.pm, 1'b1);
`endif
    repeat (4) step();
    check("wrap_hours", {bus.h10, bus.h1}, hour_digits(0));
    check("wrap_min", {bus.m10, bus.m1}, 8'h00);
`ifdef TWELVE_HOUR_EN
    check("wrap_pm", bus.pm, 1'b0);
`endif

    // SET_HOUR blink, 24 presses, held button.
    press(1'b1);
    check("set_hour_mode", bus.mode, 2'd1);
    check("set_hour_blank0", bus.blank, 4'b0000);
    repeat (4) step();
    check("set_hour_blink", bus.blank, 4'b1100);
    saved_h = m_tod / 3600;
    repeat (24) press(1'b0);
    check("hour_24_presses", {bus.h10, bus.h1}, hour_digits(saved_h));
    bus.btn_inc = 1'b1;
    repeat (100) step();
    bus.btn_inc = 1'b0;
    step(); step();
    check("held_inc", {bus.h10, bus.h1}, hour_digits((saved_h + 1) % 24));

    // SET_MIN wrap without carry, then exit timing.
    press(1'b1);
    saved_h = m_tod / 3600;
    n = (59 - (m_tod / 60) % 60 + 60) % 60;
    repeat (n) press(1'b0);
    press(1'b0);
    check("min_wrap", {bus.m10, bus.m1}, 8'h00);
    check("min_wrap_hours", {bus.h10, bus.h1}, hour_digits(saved_h));
    press(1'b1);
    for (int i = 3; i <= 4; i++) begin
      step();
      check("exit_first_pulse", bus.sec_pulse, i == 4);
    end

    // Simultaneous mode and inc in RUN.
    saved_h = m_tod / 3600;
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    step(); step();
    check("simul_mode", bus.mode, 2'd1);
    check("simul_hours", {bus.h10, bus.h1}, hour_digits(saved_h));
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step(); step();

    // Reset during SET_MIN with buttons held.
    press(1'b1);
    bus.btn_inc = 1'b1;
    step(); step();
    bus.btn_mode = 1'b1;
    rst = 1'b1;
    step();
    check("mid_rst_hours", {bus.h10, bus.h1}, hour_digits(0));
    check("mid_rst_mode", bus.mode, 2'd0);
    rst = 1'b0;
    repeat (10) step();
    check("held_through_rst", bus.mode, 2'd0);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step(); step();
    press(1'b1);
    check("post_rst_press", bus.mode, 2'd1);

    // Random button activity with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) bus.btn_mode = ~bus.btn_mode;
      if ($urandom_range(0, 99) < 30) bus.btn_inc = ~bus.btn_inc;
      if ($urandom_range(0, 49) == 0) begin
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
